// File: rtl/umi_sched_pkg.sv
`default_nettype none
// umi_sched_pkg: shared opcodes, EOM position, arbiter states and response-expectation helper.
// Revision: 1.0
package umi_sched_pkg;

  localparam logic [4:0] UMI_REQ_READ   = 5'h01;
  localparam logic [4:0] UMI_REQ_WRITE  = 5'h03;
  localparam logic [4:0] UMI_REQ_POSTED = 5'h05;
  localparam logic [4:0] UMI_REQ_ATOMIC = 5'h09;

  localparam int UMI_EOM_BIT = 22;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } sched_state_t;

  function automatic logic resp_expected(input logic [4:0] opcode);
    return (opcode == UMI_REQ_READ) || (opcode == UMI_REQ_WRITE) ||
           (opcode == UMI_REQ_ATOMIC);
  endfunction

endpackage
`default_nettype wire

// File: rtl/umi_sched_tagfifo.sv
`default_nettype none
// umi_sched_tagfifo: in-order FIFO of requester indices awaiting a device response.
// Revision: 1.0
module umi_sched_tagfifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_tag,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_COUNT = DEPTH[PW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      wr_ptr;
  logic [PW:0]      rd_ptr;
  logic [PW:0]      count;

  // Extra pointer bit lets the difference distinguish full from empty.
  assign count = wr_ptr - rd_ptr;
  assign empty = (count == '0);
  assign full  = (count == FULL_COUNT);
  assign head  = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)  wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[PW-1:0]] <= push_tag;
  end

endmodule
`default_nettype wire

// File: rtl/umi_mem_scheduler.sv
`default_nettype none
// umi_mem_scheduler: round-robin, packet-locked sharing of one UMI device port by NREQ hosts;
// responses are routed back through an in-order tag FIFO. Revision: 1.0
module umi_mem_scheduler
  import umi_sched_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int CW       = 32,
  parameter int AW       = 64,
  parameter int DW       = 128,
  parameter int TAGDEPTH = 8
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic [NREQ-1:0]      host_req_valid,
  input  logic [NREQ*CW-1:0]   host_req_cmd,
  input  logic [NREQ*AW-1:0]   host_req_dstaddr,
  input  logic [NREQ*AW-1:0]   host_req_srcaddr,
  input  logic [NREQ*DW-1:0]   host_req_data,
  output logic [NREQ-1:0]      host_req_ready,
  output logic [NREQ-1:0]      host_resp_valid,
  output logic [CW-1:0]        host_resp_cmd,
  output logic [AW-1:0]        host_resp_dstaddr,
  output logic [AW-1:0]        host_resp_srcaddr,
  output logic [DW-1:0]        host_resp_data,
  input  logic [NREQ-1:0]      host_resp_ready,
  output logic                 udev_req_valid,
  output logic [CW-1:0]        udev_req_cmd,
  output logic [AW-1:0]        udev_req_dstaddr,
  output logic [AW-1:0]        udev_req_srcaddr,
  output logic [DW-1:0]        udev_req_data,
  input  logic                 udev_req_ready,
  input  logic                 udev_resp_valid,
  input  logic [CW-1:0]        udev_resp_cmd,
  input  logic [AW-1:0]        udev_resp_dstaddr,
  input  logic [AW-1:0]        udev_resp_srcaddr,
  input  logic [DW-1:0]        udev_resp_data,
  output logic                 udev_resp_ready,
  output logic                 err_unexpected
);

  localparam int GW = $clog2(NREQ);

  sched_state_t  state, state_nxt;
  logic [GW-1:0] gnt, gnt_nxt;
  logic [GW-1:0] rr_ptr, rr_ptr_nxt;
  logic [GW-1:0] sel;
  logic [GW-1:0] head;
  logic [CW-1:0] sel_cmd;
  logic          fwd, accept, push, pop, full, empty;

  // First valid requester at or after ptr, wrapping modulo NREQ.
  function automatic logic [GW-1:0] rr_pick(input logic [NREQ-1:0] valid,
                                            input logic [GW-1:0]   ptr);
    int idx;
    rr_pick = ptr;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NREQ;
      if (valid[idx]) rr_pick = GW'(idx);
    end
  endfunction

  function automatic logic [GW-1:0] next_idx(input logic [GW-1:0] idx);
    return (int'(idx) == NREQ - 1) ? '0 : idx + 1'b1;
  endfunction

  always_comb begin
    state_nxt  = state;
    gnt_nxt    = gnt;
    rr_ptr_nxt = rr_ptr;
    sel        = gnt;
    fwd        = 1'b0;
    unique case (state)
      IDLE: begin
        sel = rr_pick(host_req_valid, rr_ptr);
        fwd = ~full & (|host_req_valid);
      end
      LOCKED: fwd = 1'b1;
    endcase
    sel_cmd        = host_req_cmd[sel*CW +: CW];
    udev_req_valid = nreset & fwd & host_req_valid[sel];
    host_req_ready = '0;
    if (nreset && fwd) host_req_ready[sel] = udev_req_ready;
    accept = udev_req_valid & udev_req_ready;
    // Only an IDLE-state acceptance can be the first beat of a packet.
    push   = accept & (state == IDLE) & resp_expected(sel_cmd[4:0]);
    if (accept) begin
      if (sel_cmd[UMI_EOM_BIT]) begin
        state_nxt  = IDLE;
        rr_ptr_nxt = next_idx(sel);
      end else begin
        state_nxt = LOCKED;
        gnt_nxt   = sel;
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state  <= IDLE;
      gnt    <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_nxt;
      gnt    <= gnt_nxt;
      rr_ptr <= rr_ptr_nxt;
    end
  end

  assign udev_req_cmd     = sel_cmd;
  assign udev_req_dstaddr = host_req_dstaddr[sel*AW +: AW];
  assign udev_req_srcaddr = host_req_srcaddr[sel*AW +: AW];
  assign udev_req_data    = host_req_data[sel*DW +: DW];

  umi_sched_tagfifo #(
    .WIDTH (GW),
    .DEPTH (TAGDEPTH)
  ) u_tagfifo (
    .clk      (clk),
    .nreset   (nreset),
    .push     (push),
    .push_tag (sel),
    .pop      (pop),
    .full     (full),
    .empty    (empty),
    .head     (head)
  );

  // With no outstanding tag the beat is sunk and flagged instead of routed.
  always_comb begin
    host_resp_valid = '0;
    if (nreset && udev_resp_valid && !empty) host_resp_valid[head] = 1'b1;
    udev_resp_ready = nreset & (empty | host_resp_ready[head]);
    err_unexpected  = nreset & udev_resp_valid & empty;
  end

  assign pop = udev_resp_valid & udev_resp_ready & ~empty & udev_resp_cmd[UMI_EOM_BIT];

  assign host_resp_cmd     = udev_resp_cmd;
  assign host_resp_dstaddr = udev_resp_dstaddr;
  assign host_resp_srcaddr = udev_resp_srcaddr;
  assign host_resp_data    = udev_resp_data;

endmodule
`default_nettype wire

// File: doc/umi_mem_scheduler.md
Name: umi_mem_scheduler

Overview:
- Shares one UMI device port (e.g. a umi_fifoflex feeding a umi_memagent) between NREQ host requesters.
- Request side: round-robin arbitration with per-packet lock; a granted packet's beats are never interleaved with another requester's beats.
- Response side: an in-order tag FIFO routes each device response back to the requester that issued the matching request.

Parameters:
- NREQ, 4, number of host requesters (2..8)
- CW, 32, UMI command width
- AW, 64, UMI address width
- DW, 128, UMI data width (same on host and device sides)
- TAGDEPTH, 8, outstanding response-expecting packets (power of 2)

Ports:
- clk  input  1  clock
- nreset  input  1  async active-low reset
- host_req_valid  input  NREQ  per-requester request valid
- host_req_cmd  input  NREQ*CW  packed, requester i at [i*CW +: CW]
- host_req_dstaddr  input  NREQ*AW  packed
- host_req_srcaddr  input  NREQ*AW  packed
- host_req_data  input  NREQ*DW  packed
- host_req_ready  output  NREQ  per-requester ready
- host_resp_valid  output  NREQ  one-hot response valid
- host_resp_cmd  output  CW  broadcast
- host_resp_dstaddr  output  AW  broadcast
- host_resp_srcaddr  output  AW  broadcast
- host_resp_data  output  DW  broadcast
- host_resp_ready  input  NREQ  per-requester ready
- udev_req_valid/cmd/dstaddr/srcaddr/data  output  1/CW/AW/AW/DW  device request
- udev_req_ready  input  1
- udev_resp_valid/cmd/dstaddr/srcaddr/data  input  1/CW/AW/AW/DW  device response
- udev_resp_ready  output  1
- err_unexpected  output  1  one-cycle pulse: response arrived with tag FIFO empty

Behaviour:
- Reset:
  - Clock is clk; reset is nreset, asynchronous, active-low.
  - State=IDLE, rr_ptr=0, tag FIFO empty, err_unexpected=0.
  - All host_req_ready=0, host_resp_valid=0, udev_req_valid=0.
- Command decode:
  - opcode=cmd[4:0]; EOM=cmd[22].
  - Response expected when opcode is in {5'h01 READ, 5'h03 WRITE, 5'h09 ATOMIC}.
  - 5'h05 POSTED and all other opcodes expect no response.
- Arbiter FSM, state IDLE:
  - If tag FIFO full, no grant: all host_req_ready=0, udev_req_valid=0.
  - Otherwise, grant goes to the first valid requester at or after rr_ptr (mod NREQ). Selection is combinational, so request latency is 0 cycles.
  - udev_req_* = granted requester's fields; host_req_ready[g] = udev_req_ready; all other readies are 0.
  - On an accepted beat with EOM=0: latch g, go to LOCKED.
  - On an accepted beat with EOM=1: stay IDLE, rr_ptr <= g+1 mod NREQ.
- Arbiter FSM, state LOCKED:
  - Only requester g is forwarded, regardless of other valids or FIFO full.
  - Accepted beat with EOM=1: go to IDLE, rr_ptr <= g+1.
  - Deasserted valid from g mid-packet: stay LOCKED; no timeout.
- Tag FIFO:
  - Push g on the first accepted beat of a response-expecting packet. This is the IDLE-state acceptance, which is the only first beat.
  - Pop on an accepted udev_resp beat with EOM=1.
  - Simultaneous push and pop are both honored; count is unchanged.
  - Full blocks new grants only; a locked packet always completes.
  - Pointers are log2(TAGDEPTH)+1 bits and wrap naturally.
- Response path (no added latency):
  - host_resp_valid = onehot(head) & {NREQ{udev_resp_valid & ~empty}}.
  - udev_resp_ready = host_resp_ready[head]; payload passes straight through.
  - Multi-beat responses all route to head until the EOM pop.
- Unexpected response (valid while FIFO empty):
  - udev_resp_ready=1, the beat is dropped.
  - err_unexpected pulses 1 cycle per dropped beat.
- Reset mid-packet: returns immediately to the reset state; partial packets and outstanding tags are discarded.
- Starvation bound: a continuously valid requester is granted within NREQ-1 packets.

Decomposition:
- Shared package umi_sched_pkg:
  - opcode localparams (UMI_REQ_READ, UMI_REQ_WRITE, UMI_REQ_POSTED, UMI_REQ_ATOMIC)
  - EOM bit index 22
  - state enum {IDLE, LOCKED}
  - function resp_expected(opcode)
- One sub-module: umi_sched_tagfifo. Synchronous FIFO, width $clog2(NREQ), depth TAGDEPTH; outputs full, empty, head.
- Round-robin selection stays inline as a function.

Test Plan:
- Round-robin: requesters 0..3 each assert one single-beat READ (EOM=1) in the same cycle, udev_req_ready=1 → grant order 0,1,2,3 on consecutive cycles; tag FIFO holds 0,1,2,3; rr_ptr ends at 0.
- Packet lock: requester 1 sends a 3-beat WRITE (EOM on beat 3) while requester 2 is valid; udev_req_ready toggles 1,0,1,1 → beats 1,2,3 all from requester 1, then requester 2 is granted; no interleave.
- Routing: responses returned in order, 2-beat response for tag 0, 1-beat for tag 3; host_resp_ready[3]=0 for 2 cycles → host_resp_valid=4'b0001 for 2 beats, then 4'b1000 held for 2 stalled cycles; udev_resp_ready=0 while stalled.
- Posted and full: 8 READs fill FIFO (TAGDEPTH=8) → 9th READ sees host_req_ready=0. Then:
  - A POSTED from another requester is also blocked.
  - One response EOM frees a slot and the grant resumes the next cycle.
  - POSTED packets never push a tag.
- Unexpected: udev_resp_valid=1 for 2 beats with FIFO empty → udev_resp_ready=1, host_resp_valid=0, err_unexpected high for exactly 2 cycles.
- Reset mid-packet: nreset low during beat 2 of 4 in LOCKED → all outputs 0 asynchronously; after release, state IDLE, FIFO empty, rr_ptr=0.
